// File: rtl/comparator_72.sv
// comparator_72 -- pipelined signed argmax over 72 lanes.
//
// Picks the largest of 72 two's-complement scores and reports its value and
// lane index. A binary reduction tree of 7 registered levels
// (72->36->18->9->5->3->2->1) accepts one new vector per clock.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, ACTIVE-HIGH despite the name; clears all state
//   run    qualifies d; the vector on d is sampled when run=1
//   d      72 packed scores, lane i = d[i*N_LEN +: N_LEN] (lane 0 in the LSBs)
//   valid  num/q hold the result for a vector sampled 7 edges earlier
//   num    lane index (0..71) of the maximum; lowest index wins on ties
//   q      value of the maximum lane
//
// Handshake: there is no backpressure. A vector presented with run=1 at
// edge k is reported with valid=1 after edge k+6 for exactly one cycle;
// num/q carry no meaning while valid=0.

// One registered reduction level. Pairs adjacent candidates (0,1), (2,3), ...
// and keeps the lower-index one unless the higher-index one is strictly
// greater. An odd trailing candidate is registered unchanged.
module comparator_72_level #(
    parameter int N_LEN    = 24,
    parameter int CHAR_LEN = 7,
    parameter int IN_CNT   = 72,
    parameter int OUT_CNT  = 36
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IN_CNT*N_LEN-1:0]     in_val,
    input  logic [IN_CNT*CHAR_LEN-1:0]  in_idx,
    output logic [OUT_CNT*N_LEN-1:0]    out_val,
    output logic [OUT_CNT*CHAR_LEN-1:0] out_idx
);

    logic [OUT_CNT*N_LEN-1:0]    nxt_val;
    logic [OUT_CNT*CHAR_LEN-1:0] nxt_idx;

    always_comb begin
        nxt_val = '0;
        nxt_idx = '0;
        for (int p = 0; p < IN_CNT / 2; p++) begin
            if ($signed(in_val[(2*p+1)*N_LEN +: N_LEN]) >
                $signed(in_val[(2*p)*N_LEN +: N_LEN])) begin
                nxt_val[p*N_LEN +: N_LEN]       = in_val[(2*p+1)*N_LEN +: N_LEN];
                nxt_idx[p*CHAR_LEN +: CHAR_LEN] = in_idx[(2*p+1)*CHAR_LEN +: CHAR_LEN];
            end else begin
                nxt_val[p*N_LEN +: N_LEN]       = in_val[(2*p)*N_LEN +: N_LEN];
                nxt_idx[p*CHAR_LEN +: CHAR_LEN] = in_idx[(2*p)*CHAR_LEN +: CHAR_LEN];
            end
        end
        // Odd leftover rides through this level in the last output slot.
        if (IN_CNT % 2 == 1) begin
            nxt_val[(OUT_CNT-1)*N_LEN +: N_LEN] =
                in_val[(IN_CNT-1)*N_LEN +: N_LEN];
            nxt_idx[(OUT_CNT-1)*CHAR_LEN +: CHAR_LEN] =
                in_idx[(IN_CNT-1)*CHAR_LEN +: CHAR_LEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_val <= '0;
            out_idx <= '0;
        end else begin
            out_val <= nxt_val;
            out_idx <= nxt_idx;
        end
    end

endmodule

module comparator_72 #(
    parameter int N_LEN    = 24,
    parameter int CHAR_LEN = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [72*N_LEN-1:0]   d,
    output logic                  valid,
    output logic [CHAR_LEN-1:0]   num,
    output logic [N_LEN-1:0]      q
);

    localparam int C0 = 72;
    localparam int C1 = 36;
    localparam int C2 = 18;
    localparam int C3 = 9;
    localparam int C4 = 5;
    localparam int C5 = 3;
    localparam int C6 = 2;
    localparam int C7 = 1;

    logic [C0*CHAR_LEN-1:0] idx0;
    logic [C1*N_LEN-1:0] val1;  logic [C1*CHAR_LEN-1:0] idx1;
    logic [C2*N_LEN-1:0] val2;  logic [C2*CHAR_LEN-1:0] idx2;
    logic [C3*N_LEN-1:0] val3;  logic [C3*CHAR_LEN-1:0] idx3;
    logic [C4*N_LEN-1:0] val4;  logic [C4*CHAR_LEN-1:0] idx4;
    logic [C5*N_LEN-1:0] val5;  logic [C5*CHAR_LEN-1:0] idx5;
    logic [C6*N_LEN-1:0] val6;  logic [C6*CHAR_LEN-1:0] idx6;
    logic [C7*N_LEN-1:0] val7;  logic [C7*CHAR_LEN-1:0] idx7;
    logic [6:0]          valid_sr;

    // Every candidate enters the tree tagged with its own lane number.
    for (genvar i = 0; i < C0; i++) begin : g_lane_idx
        assign idx0[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(i);
    end

    comparator_72_level #(.N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN), .IN_CNT(C0), .OUT_CNT(C1))
        u_lvl1 (.clk(clk), .rst(rst_n), .in_val(d),    .in_idx(idx0), .out_val(val1), .out_idx(idx1));
    comparator_72_level #(.N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN), .IN_CNT(C1), .OUT_CNT(C2))
        u_lvl2 (.clk(clk), .rst(rst_n), .in_val(val1), .in_idx(idx1), .out_val(val2), .out_idx(idx2));
    comparator_72_level #(.N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN), .IN_CNT(C2), .OUT_CNT(C3))
        u_lvl3 (.clk(clk), .rst(rst_n), .in_val(val2), .in_idx(idx2), .out_val(val3), .out_idx(idx3));
    comparator_72_level #(.N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN), .IN_CNT(C3), .OUT_CNT(C4))
        u_lvl4 (.clk(clk), .rst(rst_n), .in_val(val3), .in_idx(idx3), .out_val(val4), .out_idx(idx4));
    comparator_72_level #(.N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN), .IN_CNT(C4), .OUT_CNT(C5))
        u_lvl5 (.clk(clk), .rst(rst_n), .in_val(val4), .in_idx(idx4), .out_val(val5), .out_idx(idx5));
    comparator_72_level #(.N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN), .IN_CNT(C5), .OUT_CNT(C6))
        u_lvl6 (.clk(clk), .rst(rst_n), .in_val(val5), .in_idx(idx5), .out_val(val6), .out_idx(idx6));
    comparator_72_level #(.N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN), .IN_CNT(C6), .OUT_CNT(C7))
        u_lvl7 (.clk(clk), .rst(rst_n), .in_val(val6), .in_idx(idx6), .out_val(val7), .out_idx(idx7));

    // run travels alongside the data; bit 0 matches level 1, bit 6 the output.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_sr <= '0;
        end else begin
            valid_sr <= {valid_sr[5:0], run};
        end
    end

    assign valid = valid_sr[6];
    assign num   = idx7;
    assign q     = val7;

endmodule

// File: tb/tb_comparator_72.sv
module tb_comparator_72;

    localparam int N_LEN    = 24;
    localparam int CHAR_LEN = 7;
    localparam int LANES    = 72;
    localparam int LAT      = 7;

    typedef struct {
        logic             v;
        int               num;
        logic [N_LEN-1:0] q;
    } exp_t;

    logic                     clk;
    logic                     rst_n;   // active-high reset
    logic                     run;
    logic [LANES*N_LEN-1:0]   d;
    logic                     valid;
    logic [CHAR_LEN-1:0]      num;
    logic [N_LEN-1:0]         q;

    int   n_total;
    int   n_bad;
    exp_t exp_q[$];

    comparator_72 #(.N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .d(d),
        .valid(valid), .num(num), .q(q)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Argmax straight from the rule: scan lanes in ascending order, take a
    // new lane only when strictly greater -> lowest index among equal maxima.
    function automatic exp_t ref_argmax(input logic r, input logic [LANES*N_LEN-1:0] v);
        exp_t e;
        int   best;
        int   cur;
        e.v   = r;
        e.num = 0;
        best  = int'($signed(v[N_LEN-1:0]));
        for (int i = 1; i < LANES; i++) begin
            cur = int'($signed(v[i*N_LEN +: N_LEN]));
            if (cur > best) begin
                best  = cur;
                e.num = i;
            end
        end
        e.q = best[N_LEN-1:0];
        return e;
    endfunction

    function automatic exp_t empty_exp();
        exp_t e;
        e.v = 1'b0; e.num = 0; e.q = '0;
        return e;
    endfunction

    // Expected-output delay line: exp_q[0] is what the outputs should show
    // after the most recent edge.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back(empty_exp());
        end else begin
            void'(exp_q.pop_front());
            exp_q.push_back(ref_argmax(run, d));
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, expv);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        e = exp_q[0];
        check("valid", {31'b0, valid}, {31'b0, e.v});
        if (e.v) begin
            check("num", {25'b0, num}, e.num);
            check("q",   {8'b0, q},    {8'b0, e.q});
        end
    endtask

    // ---------------- drivers ----------------
    function automatic logic [LANES*N_LEN-1:0] fill(input logic [N_LEN-1:0] val);
        logic [LANES*N_LEN-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*N_LEN +: N_LEN] = val;
        return v;
    endfunction

    function automatic logic [LANES*N_LEN-1:0] peak(input int lane,
                                                      input logic [N_LEN-1:0] pval,
                                                      input logic [N_LEN-1:0] other);
        logic [LANES*N_LEN-1:0] v;
        v = fill(other);
        v[lane*N_LEN +: N_LEN] = pval;
        return v;
    endfunction

    // Check the outputs produced by the last edge, then present the next input.
    task automatic cycle(input logic r, input logic [LANES*N_LEN-1:0] v);
        @(negedge clk);
        check_outputs();
        run = r;
        d   = v;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        run   = 1'b0;
        #1;
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_num",   {25'b0, num},   32'd0);
        check("rst_q",     {8'b0, q},      32'd0);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b0;
    endtask

    function automatic logic [LANES*N_LEN-1:0] rand_vec(input int mode);
        logic [LANES*N_LEN-1:0] v;
        logic [N_LEN-1:0]       c;
        c = N_LEN'($urandom);
        for (int i = 0; i < LANES; i++) begin
            case (mode)
                0:       v[i*N_LEN +: N_LEN] = N_LEN'($urandom);
                1:       v[i*N_LEN +: N_LEN] = N_LEN'($urandom_range(0, 4)) - N_LEN'(2);
                default: v[i*N_LEN +: N_LEN] = c;
            endcase
        end
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [LANES*N_LEN-1:0] v;
        int lanes4[4];
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b1;
        run     = 1'b0;
        d       = '0;

        // Reset state.
        @(negedge clk);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_num",   {25'b0, num},   32'd0);
        check("reset_q",     {8'b0, q},      32'd0);
        rst_n = 1'b0;

        // Single peak at lane 36, run held: valid must rise after 7 edges and stay.
        v = peak(36, 24'h000001, 24'h800000);
        for (int i = 0; i < 12; i++) cycle(1'b1, v);

        // Ties and sign/boundary cases.
        cycle(1'b1, fill(24'h000005));
        v = fill(24'h000000);
        v[10*N_LEN +: N_LEN] = 24'h7FFFFF;
        v[50*N_LEN +: N_LEN] = 24'h7FFFFF;
        cycle(1'b1, v);
        cycle(1'b1, peak(0,  24'h000010, 24'hFFFFF0));
        cycle(1'b1, peak(71, 24'h7FFFFF, 24'h800000));
        cycle(1'b1, peak(8,  24'hFFFFFF, 24'hFFFFFE));

        // Back-to-back single peaks, value = lane number.
        lanes4 = '{3, 40, 71, 64};
        for (int i = 0; i < 4; i++)
            cycle(1'b1, peak(lanes4[i], N_LEN'(lanes4[i]), 24'h800000));

        // run gap 1,0,1 then drain.
        cycle(1'b1, peak(20, 24'h000100, 24'h000000));
        cycle(1'b0, peak(21, 24'h000100, 24'h000000));
        cycle(1'b1, peak(22, 24'h000100, 24'h000000));
        for (int i = 0; i < LAT + 1; i++) cycle(1'b0, '0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), rand_vec($urandom_range(0, 2)));

        // Reset with three vectors in flight; nothing stale may appear.
        cycle(1'b1, peak(5,  24'h000050, 24'h800000));
        cycle(1'b1, peak(6,  24'h000060, 24'h800000));
        cycle(1'b1, peak(7,  24'h000070, 24'h800000));
        mid_reset();
        for (int i = 0; i < LAT + 3; i++) cycle(1'b0, peak(9, 24'h000001, 24'h000000));
        for (int i = 0; i < 10; i++) cycle(1'b1, rand_vec(0));
        for (int i = 0; i < LAT + 2; i++) cycle(1'b0, '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/comparator_72.md
Name: comparator_72

Overview:
Pipelined signed argmax unit. Takes 72 two's-complement scores packed on one bus and returns the maximum value and its lane index. It sits at the output of the training datapath's character-score layer and selects the winning character out of 72 candidates. The unit is fully pipelined and accepts one new vector per cycle.

Parameters:
N_LEN, 24, width of each signed score (two's complement, from consts_train.vh).
CHAR_LEN, 7, width of the index output; must satisfy 2^CHAR_LEN >= 72.
Lane count is fixed at 72 and is not a parameter.

Ports:
clk  input  1  clock; all registers update on the rising edge.
rst_n  input  1  asynchronous reset, active-high (the port keeps the codebase name); clears all state.
run  input  1  qualifies d; when high, d is sampled into stage 1 on the edge.
d  input  72*N_LEN  packed scores; lane i = d[i*N_LEN +: N_LEN], so lane 0 is the LSBs.
valid  output  1  high when num/q hold the result for a sampled vector.
num  output  CHAR_LEN  index (0..71) of the maximum lane.
q  output  N_LEN  value of the maximum lane.

Behaviour:
- Reset, while rst_n=1, asynchronous:
  - All pipeline value, index and valid registers clear to 0.
  - Outputs are valid=0, num=0, q=0.
- Comparison is signed: 24'h800000 is the most negative value, 24'h7FFFFF the most positive.
- Reduction tree, 7 registered levels, 72→36→18→9→5→3→2→1:
  - Each level pairs adjacent candidates (0,1), (2,3), ... in ascending index order.
  - An odd leftover (last candidate) passes through unchanged, with its value and index registered.
  - Each candidate carries its value plus its original 7-bit lane index.
- Pair rule: the higher-index element wins only if strictly greater. Ties go to the lower index, so overall the lowest index among equal maxima is reported.
- Latency: a vector sampled with run=1 at edge k appears on num/q with valid=1 after edge k+6, i.e. 7 register stages. The output is registered, with no combinational path from d to outputs.
- valid is run delayed through a 7-bit shift register that is reset to 0.
  - Holding run high gives valid high continuously after the latency.
  - Each cycle's result corresponds to d sampled 7 cycles earlier.
- When run=0 the data stages may still load d (don't-care). valid for that slot is 0, and num/q are don't-care when valid=0.
- Throughput is 1 vector per clock, with no backpressure and no stall.
- Reset mid-operation flushes the pipeline: valid drops immediately (asynchronously) and stays 0 until 7 cycles after run is reasserted following reset release.
- The index never exceeds 71, and no overflow is possible since no arithmetic is performed, only compare and select.

Test Plan:
- Reset, single peak: rst_n=1 for 1 cycle with run=0, then release and hold run=1 with d = lane 36 = 24'h000001, all other lanes 24'h800000 → valid rises 7 clocks after the first sampled edge; num=36, q=24'h000001; valid stays high while run is held.
- Ties: all lanes = 24'h000005 → num=0, q=5. Lanes 10 and 50 = 24'h7FFFFF, others 0 → num=10.
- Boundaries and sign: max at lane 0 (24'h000010, others 24'hFFFFF0) → num=0. Max at lane 71 (24'h7FFFFF, others 24'h800000) → num=71, q=24'h7FFFFF. All lanes negative, lane 8 = 24'hFFFFFF, others 24'hFFFFFE → num=8, q=24'hFFFFFF.
- Back-to-back streaming: apply a different single-peak vector each cycle at lanes 3, 40, 71, 64 (value = lane number, others 24'h800000) → consecutive results num=3, 40, 71, 64 with q=3, 40, 71, 64 on 4 consecutive cycles, 7 cycles after input.
- run gap: run pattern 1,0,1 → valid pattern 1,0,1 delayed by 7 cycles.
- Reset mid-flight: assert rst_n for 1 cycle while 3 vectors are in flight → valid=0, num=0, q=0 immediately, and no stale results emerge afterwards.
